// File: rtl/fifo_drain_reader_if.sv
// Stream/FIFO bundle for fifo_drain_reader: the burst-control inputs, the FIFO
// read side and the valid/ready output stream.
interface fifo_drain_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
);
    logic                  en;
    logic                  start;
    logic [CNT_WIDTH-1:0]  len;
    logic                  fifo_empty;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  word_cnt;

    modport master (
        input  en, start, len, fifo_empty, fifo_data, out_ready,
        output fifo_rd, out_data, out_valid, busy, done, word_cnt
    );

    modport slave (
        output en, start, len, fifo_empty, fifo_data, out_ready,
        input  fifo_rd, out_data, out_valid, busy, done, word_cnt
    );
endinterface

// File: rtl/fifo_drain_reader.sv
// Burst reader for a 1-cycle-latency FIFO: issues LEN read strobes and re-times the
// returned words through a 2-entry skid buffer onto a valid/ready stream.
module fifo_drain_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_drain_reader_if.master    bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_WIDTH-1:0]  len_r;
    logic [CNT_WIDTH-1:0]  issued_r;
    logic [CNT_WIDTH-1:0]  word_cnt_r;
    logic                  inflight_r;
    logic [1:0]            occ_r;
    logic [DATA_WIDTH-1:0] skid0_r;
    logic [DATA_WIDTH-1:0] skid1_r;
    logic                  pop_s;
    logic                  rd_s;
    logic [2:0]            pending_s;

    // Read-issue decision; pending_s is the skid occupancy expected after this edge,
    // and a new read is allowed only if its word will still find a free slot.
    always_comb begin
        pop_s     = (occ_r != 2'd0) && bus.out_ready;
        pending_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_s      = (state_r == ST_READ) && bus.en && !bus.fifo_empty &&
                    (issued_r < len_r) && (pending_s < 3'd2);
    end

    // Burst state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; READ leaves on the edge that issues the final read.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        state_nxt_s = ST_READ;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if ((issued_r == len_r) || (rd_s && ((issued_r + CNT_ONE) == len_r))) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if ((word_cnt_r == len_r) || (pop_s && ((word_cnt_r + CNT_ONE) == len_r))) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Burst length, issued-read count and delivered-word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r      <= '0;
            issued_r   <= '0;
            word_cnt_r <= '0;
        end else if ((state_r == ST_IDLE) && bus.start) begin
            len_r      <= bus.len;
            issued_r   <= '0;
            word_cnt_r <= '0;
        end else begin
            if (rd_s) begin
                issued_r <= issued_r + CNT_ONE;
            end
            if (pop_s && (word_cnt_r != len_r)) begin
                word_cnt_r <= word_cnt_r + CNT_ONE;
            end
        end
    end

    // Skid buffer: entry 0 is the stream head; a capture during a pop refills behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= 1'b0;
            occ_r      <= 2'd0;
            skid0_r    <= '0;
            skid1_r    <= '0;
        end else begin
            inflight_r <= rd_s;
            case ({inflight_r, pop_s})
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        skid0_r <= bus.fifo_data;
                    end else begin
                        skid0_r <= skid1_r;
                        skid1_r <= bus.fifo_data;
                    end
                end
                2'b01: begin
                    skid0_r <= skid1_r;
                    occ_r   <= occ_r - 2'd1;
                end
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        skid0_r <= bus.fifo_data;
                    end else begin
                        skid1_r <= bus.fifo_data;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign bus.fifo_rd   = rd_s;
    assign bus.out_valid = (occ_r != 2'd0);
    assign bus.out_data  = skid0_r;
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.done      = (state_r == ST_DONE);
    assign bus.word_cnt  = word_cnt_r;
endmodule
